// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the jetpack runner.
//   game_state_e : round phase encoding, shared with barry/obstacle/animator
//   bcd_digit_t  : one BCD score digit
//   DEF_*        : default timing constants for a 50 MHz clk
`timescale 1ns/1ps
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_CRASH     = 3'd3,
    ST_OVER      = 3'd4
  } game_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned DEF_BASE_PERIOD  = 833_333;  // 60 Hz at 50 MHz
  localparam int unsigned DEF_PERIOD_STEP  = 41_666;
  localparam int unsigned DEF_MIN_PERIOD   = 416_666;
  localparam int unsigned DEF_LEVEL_PTS    = 10;
  localparam int unsigned DEF_MAX_LEVEL    = 15;
  localparam int unsigned DEF_COUNT_FRAMES = 90;
  localparam int unsigned DEF_CRASH_FRAMES = 30;

endpackage

// File: rtl/game_sequencer_bcd_counter4.sv
// bcd_counter4: four-digit BCD score counter that saturates at 9999.
//   clk, reset_n : clock, synchronous active-low reset
//   clr_i        : clear to 0000 (wins over inc_i)
//   inc_i        : add one point
//   digits_o     : registered digits, digit 0 in [3:0]
//   sat_o        : counter is at 9999, further increments are dropped
`timescale 1ns/1ps
module bcd_counter4
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] digits_o,
  output logic        sat_o
);

  bcd_digit_t [3:0] dig_q;
  bcd_digit_t [3:0] dig_d;
  logic             sat;
  logic             carry;

  assign sat = (dig_q == 16'h9999);

  // Ripple increment: a digit rolls 9->0 and passes the carry up.
  always_comb begin
    dig_d = dig_q;
    carry = inc_i & ~sat;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig_q[i] == 4'd9) begin
          dig_d[i] = 4'd0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (clr_i) dig_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) dig_q <= '0;
    else          dig_q <= dig_d;
  end

  assign digits_o = dig_q;
  assign sat_o    = sat;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round controller for the jetpack runner.
//   clk, reset_n   : clock, synchronous active-low reset
//   start          : player button level, rising edges only
//   collide        : Barry overlaps an obstacle (level)
//   obs_passed     : one-cycle pulse, an obstacle scrolled past
//   frame_tick     : one-cycle motion step pulse (all states but IDLE)
//   run            : high in PLAY only
//   game_over      : high in OVER
//   state          : current game_state_e encoding
//   score_bcd      : four BCD digits
//   level          : difficulty level, shortens the frame period
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | waiting for first start press, frame timer held
// ST_COUNTDOWN | round cleared, COUNT_FRAMES ticks before play
// ST_PLAY      | motion runs, obstacles score, collision ends play
// ST_CRASH     | crash animation for CRASH_FRAMES ticks
// ST_OVER      | final score shown, start press begins a new round
`timescale 1ns/1ps
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned BASE_PERIOD  = DEF_BASE_PERIOD,
  parameter int unsigned PERIOD_STEP  = DEF_PERIOD_STEP,
  parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int unsigned LEVEL_PTS    = DEF_LEVEL_PTS,
  parameter int unsigned MAX_LEVEL    = DEF_MAX_LEVEL,
  parameter int unsigned COUNT_FRAMES = DEF_COUNT_FRAMES,
  parameter int unsigned CRASH_FRAMES = DEF_CRASH_FRAMES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        collide,
  input  logic        obs_passed,
  output logic        frame_tick,
  output logic        run,
  output logic        game_over,
  output logic [2:0]  state,
  output logic [15:0] score_bcd,
  output logic [3:0]  level
);

  // Frame period for a level; the reduction is compared against the
  // headroom before subtracting so the result can never wrap.
  function automatic logic [31:0] period_for(input logic [3:0] lvl);
    logic [31:0] red;
    red = 32'(lvl) * PERIOD_STEP;
    if (red + MIN_PERIOD >= BASE_PERIOD) return MIN_PERIOD;
    else                                 return BASE_PERIOD - red;
  endfunction

  game_state_e state_q;
  logic        start_q;
  logic [31:0] tick_cnt_q;
  logic        frame_tick_q;
  logic [31:0] frames_left_q;
  logic [31:0] pts_left_q;
  logic [3:0]  level_q;
  logic        run_q;
  logic        game_over_q;

  logic        start_rise;
  logic        round_start;
  logic        score_inc;
  logic        score_sat;
  logic [31:0] reload_val;

  assign start_rise  = start & ~start_q;
  assign round_start = start_rise & ((state_q == ST_IDLE) | (state_q == ST_OVER));
  // A collision in the same cycle takes priority over the point.
  assign score_inc   = (state_q == ST_PLAY) & obs_passed & ~collide;
  // Level follows the value the timer will reload with at its next zero.
  assign reload_val  = period_for(level_q) - 32'd1;

  bcd_counter4 u_score (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (round_start),
    .inc_i    (score_inc),
    .digits_o (score_bcd),
    .sat_o    (score_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      tick_cnt_q    <= BASE_PERIOD - 32'd1;
      frame_tick_q  <= 1'b0;
      frames_left_q <= '0;
      pts_left_q    <= LEVEL_PTS - 32'd1;
      level_q       <= '0;
      run_q         <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      start_q <= start;

      // Frame timer: down-counter, tick on terminal count.
      if (state_q == ST_IDLE) begin
        tick_cnt_q   <= reload_val;
        frame_tick_q <= 1'b0;
      end else if (tick_cnt_q == '0) begin
        tick_cnt_q   <= reload_val;
        frame_tick_q <= 1'b1;
      end else begin
        tick_cnt_q   <= tick_cnt_q - 32'd1;
        frame_tick_q <= 1'b0;
      end

      // Points-in-level down-counter; no level change once score is pinned.
      if (score_inc && !score_sat) begin
        if (pts_left_q == '0) begin
          pts_left_q <= LEVEL_PTS - 32'd1;
          if (level_q != 4'(MAX_LEVEL)) level_q <= level_q + 4'd1;
        end else begin
          pts_left_q <= pts_left_q - 32'd1;
        end
      end

      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_rise) begin
            state_q       <= ST_COUNTDOWN;
            // Restart the frame timer so the first tick lands a full
            // level-0 period after entry.
            tick_cnt_q    <= BASE_PERIOD - 32'd1;
            frame_tick_q  <= 1'b0;
            frames_left_q <= COUNT_FRAMES - 32'd1;
            pts_left_q    <= LEVEL_PTS - 32'd1;
            level_q       <= '0;
            game_over_q   <= 1'b0;
          end
        end
        ST_COUNTDOWN: begin
          if (frame_tick_q) begin
            if (frames_left_q == '0) begin
              state_q <= ST_PLAY;
              run_q   <= 1'b1;
            end else begin
              frames_left_q <= frames_left_q - 32'd1;
            end
          end
        end
        ST_PLAY: begin
          if (collide) begin
            state_q       <= ST_CRASH;
            run_q         <= 1'b0;
            frames_left_q <= CRASH_FRAMES - 32'd1;
          end
        end
        ST_CRASH: begin
          if (frame_tick_q) begin
            if (frames_left_q == '0) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end else begin
              frames_left_q <= frames_left_q - 32'd1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          run_q       <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign frame_tick = frame_tick_q;
  assign run        = run_q;
  assign game_over  = game_over_q;
  assign state      = state_q;
  assign level      = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
`timescale 1ns/1ps
module tb_game_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        collide;
  logic        obs_passed;
  logic        frame_tick;
  logic        run;
  logic        game_over;
  logic [2:0]  state;
  logic [15:0] score_bcd;
  logic [3:0]  level;

  int total = 0;
  int bad   = 0;

  game_sequencer #(
    .BASE_PERIOD  (8),
    .PERIOD_STEP  (2),
    .MIN_PERIOD   (4),
    .LEVEL_PTS    (3),
    .MAX_LEVEL    (15),
    .COUNT_FRAMES (2),
    .CRASH_FRAMES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .collide    (collide),
    .obs_passed (obs_passed),
    .frame_tick (frame_tick),
    .run        (run),
    .game_over  (game_over),
    .state      (state),
    .score_bcd  (score_bcd),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; collide = 1'b0; obs_passed = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL rst_run got=%b exp=0", run); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_over got=%b exp=0", game_over); end
    total++; if (score_bcd !== 16'h0000) begin bad++; $display("FAIL rst_score got=%h exp=0000", score_bcd); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    reset_n = 1'b1;
  endtask

  // start held high: one COUNTDOWN entry, ticks every 8, PLAY after 2 ticks
  task automatic test_start_held();
    int entries;
    logic [2:0] prev, exp_state;
    logic exp_tick, exp_run;
    entries = 0;
    prev = state;
    start = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (state == 3'd1 && prev != 3'd1) entries++;
      prev = state;
      exp_tick  = (k >= 9) && (((k - 9) % 8) == 0);
      exp_state = (k < 18) ? 3'd1 : 3'd2;
      exp_run   = (k >= 18);
      total++; if (frame_tick !== exp_tick) begin bad++; $display("FAIL t1_tick k=%0d got=%b exp=%b", k, frame_tick, exp_tick); end
      total++; if (state !== exp_state) begin bad++; $display("FAIL t1_state k=%0d got=%0d exp=%0d", k, state, exp_state); end
      total++; if (run !== exp_run) begin bad++; $display("FAIL t1_run k=%0d got=%b exp=%b", k, run, exp_run); end
    end
    total++; if (entries !== 1) begin bad++; $display("FAIL t1_entries got=%0d exp=1", entries); end
    start = 1'b0;
  endtask

  // 7 points spaced 3 cycles from a level-0 reload: tick gaps 8,6,6,4,4
  task automatic test_score_level();
    logic found, exp_tick;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (frame_tick) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL t2_sync got=no_tick exp=tick"); end
    for (int j = 0; j <= 30; j++) begin
      if (j > 0) @(negedge clk);
      exp_tick = (j == 0) || (j == 8) || (j == 14) || (j == 20) || (j == 24) || (j == 28);
      total++; if (frame_tick !== exp_tick) begin bad++; $display("FAIL t2_tick j=%0d got=%b exp=%b", j, frame_tick, exp_tick); end
      if (j == 6) begin total++; if (level !== 4'd0) begin bad++; $display("FAIL t2_lvl6 got=%0d exp=0", level); end end
      if (j == 7) begin total++; if (level !== 4'd1) begin bad++; $display("FAIL t2_lvl7 got=%0d exp=1", level); end end
      if (j == 15) begin total++; if (level !== 4'd1) begin bad++; $display("FAIL t2_lvl15 got=%0d exp=1", level); end end
      if (j == 16) begin total++; if (level !== 4'd2) begin bad++; $display("FAIL t2_lvl16 got=%0d exp=2", level); end end
      obs_passed = ((j % 3) == 0) && (j <= 18);
    end
    obs_passed = 1'b0;
    total++; if (score_bcd !== 16'h0007) begin bad++; $display("FAIL t2_score got=%h exp=0007", score_bcd); end
    total++; if (level !== 4'd2) begin bad++; $display("FAIL t2_level got=%0d exp=2", level); end
    total++; if (state !== 3'd2) begin bad++; $display("FAIL t2_state got=%0d exp=2", state); end
  endtask

  // collide and obs_passed together: crash wins, game_over after 2 crash ticks
  task automatic test_crash();
    int ticks;
    logic done;
    collide = 1'b1; obs_passed = 1'b1;
    @(negedge clk);
    collide = 1'b0; obs_passed = 1'b0;
    total++; if (run !== 1'b0) begin bad++; $display("FAIL t4_run got=%b exp=0", run); end
    total++; if (state !== 3'd3) begin bad++; $display("FAIL t4_state got=%0d exp=3", state); end
    total++; if (score_bcd !== 16'h0007) begin bad++; $display("FAIL t4_score got=%h exp=0007", score_bcd); end
    ticks = 0;
    done = 1'b0;
    for (int w = 0; w < 40 && !done; w++) begin
      if (w > 0) @(negedge clk);
      if (frame_tick) begin
        ticks++;
        if (ticks == 2) begin
          total++; if (game_over !== 1'b0) begin bad++; $display("FAIL t4_over_early got=%b exp=0", game_over); end
          @(negedge clk);
          total++; if (game_over !== 1'b1) begin bad++; $display("FAIL t4_over got=%b exp=1", game_over); end
          total++; if (state !== 3'd4) begin bad++; $display("FAIL t4_state_over got=%0d exp=4", state); end
          done = 1'b1;
        end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL t4_timeout got=ticks%0d exp=2", ticks); end
  endtask

  // new round from OVER; a start press during COUNTDOWN is ignored
  task automatic test_restart();
    logic exp_tick, exp_run;
    logic [2:0] exp_state;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL t5_state got=%0d exp=1", state); end
    total++; if (score_bcd !== 16'h0000) begin bad++; $display("FAIL t5_score got=%h exp=0000", score_bcd); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL t5_level got=%0d exp=0", level); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL t5_over got=%b exp=0", game_over); end
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      exp_tick  = (k == 9) || (k == 17);
      exp_state = (k < 18) ? 3'd1 : 3'd2;
      exp_run   = (k == 18);
      total++; if (frame_tick !== exp_tick) begin bad++; $display("FAIL t5_tick k=%0d got=%b exp=%b", k, frame_tick, exp_tick); end
      total++; if (state !== exp_state) begin bad++; $display("FAIL t5_st k=%0d got=%0d exp=%0d", k, state, exp_state); end
      total++; if (run !== exp_run) begin bad++; $display("FAIL t5_run k=%0d got=%b exp=%b", k, run, exp_run); end
      start = (k == 3);
    end
    start = 1'b0;
  endtask

  // drive score to 9998, then 3 more points must pin at 9999
  task automatic test_saturate();
    for (int i = 1; i <= 9998; i++) begin
      obs_passed = 1'b1;
      @(negedge clk);
      obs_passed = 1'b0;
      @(negedge clk);
      if (i == 1000) begin
        total++; if (score_bcd !== 16'h1000) begin bad++; $display("FAIL t3_1000 got=%h exp=1000", score_bcd); end
      end
    end
    total++; if (score_bcd !== 16'h9998) begin bad++; $display("FAIL t3_9998 got=%h exp=9998", score_bcd); end
    total++; if (level !== 4'd15) begin bad++; $display("FAIL t3_level got=%0d exp=15", level); end
    for (int i = 1; i <= 3; i++) begin
      obs_passed = 1'b1;
      @(negedge clk);
      obs_passed = 1'b0;
      @(negedge clk);
      total++; if (score_bcd !== 16'h9999) begin bad++; $display("FAIL t3_sat%0d got=%h exp=9999", i, score_bcd); end
    end
    total++; if (level !== 4'd15) begin bad++; $display("FAIL t3_level_sat got=%0d exp=15", level); end
    total++; if (state !== 3'd2) begin bad++; $display("FAIL t3_state got=%0d exp=2", state); end
  endtask

  // one-cycle reset mid-PLAY returns everything to reset values
  task automatic test_mid_reset();
    int idle_ticks;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL t6_state got=%0d exp=0", state); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL t6_tick got=%b exp=0", frame_tick); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL t6_run got=%b exp=0", run); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL t6_over got=%b exp=0", game_over); end
    total++; if (score_bcd !== 16'h0000) begin bad++; $display("FAIL t6_score got=%h exp=0000", score_bcd); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL t6_level got=%0d exp=0", level); end
    idle_ticks = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (frame_tick || state != 3'd0) idle_ticks++;
    end
    total++; if (idle_ticks !== 0) begin bad++; $display("FAIL t6_idle got=%0d exp=0", idle_ticks); end
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_score_level();
    test_crash();
    test_restart();
    test_saturate();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
